// File: rtl/simple_adder.sv
// Registered WIDTH-bit adder with carry/overflow flags and wrap, unsigned-saturate or signed-saturate result.
// Latency 1 cycle from the in_valid edge; always ready, one result per cycle, no backpressure.
module simple_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             out_valid
);

    typedef enum logic [1:0] {
        MODE_WRAP     = 2'b00,
        MODE_USAT     = 2'b01,
        MODE_SSAT     = 2'b10,
        MODE_WRAP_ALT = 2'b11
    } mode_e;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             carry;
        logic             ovf;
    } res_t;

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MAX_POS  = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH:0] raw;
    logic           raw_carry;
    logic           raw_ovf;
    mode_e          mode_sel;
    res_t           res_d;
    res_t           res_q;
    logic           vld_q;

    assign raw       = {1'b0, a} + {1'b0, b};
    assign raw_carry = raw[WIDTH];
    assign raw_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (raw[WIDTH-1] != a[WIDTH-1]);
    assign mode_sel  = mode_e'(mode);

    // Flags always describe the raw addition; only the sum is clamped.
    always_comb begin
        res_d.sum   = raw[WIDTH-1:0];
        res_d.carry = raw_carry;
        res_d.ovf   = raw_ovf;
        case (mode_sel)
            MODE_USAT: begin
                if (raw_carry) begin
                    res_d.sum = ALL_ONES;
                end
            end
            MODE_SSAT: begin
                if (raw_ovf) begin
                    res_d.sum = a[WIDTH-1] ? MIN_NEG : MAX_POS;
                end
            end
            default: begin
                res_d.sum = raw[WIDTH-1:0];
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q <= '0;
            vld_q <= 1'b0;
        end else begin
            vld_q <= in_valid;
            if (in_valid) begin
                res_q <= res_d;
            end
        end
    end

    assign sum       = res_q.sum;
    assign carry_out = res_q.carry;
    assign overflow  = res_q.ovf;
    assign out_valid = vld_q;

endmodule

// File: tb/tb_simple_adder.sv
// Directed bench for simple_adder (WIDTH=4) with hand-computed expectations.
`timescale 1ns/1ps
module tb_simple_adder;

    logic       clk;
    logic       rst_n;
    logic [3:0] a;
    logic [3:0] b;
    logic       in_valid;
    logic [1:0] mode;
    logic [3:0] sum;
    logic       carry_out;
    logic       overflow;
    logic       out_valid;

    int total = 0;
    int bad   = 0;

    simple_adder #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .mode      (mode),
        .sum       (sum),
        .carry_out (carry_out),
        .overflow  (overflow),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int es, input int ec, input int eo, input int ev);
        chk({tag, ".sum"},       32'(sum),       32'(es));
        chk({tag, ".carry"},     32'(carry_out), 32'(ec));
        chk({tag, ".ovf"},       32'(overflow),  32'(eo));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(ev));
    endtask

    // Present one operation at the falling edge; return just after the sampling edge.
    task automatic apply(input logic [3:0] av, input logic [3:0] bv, input logic [1:0] mv);
        @(negedge clk);
        a        = av;
        b        = bv;
        mode     = mv;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        in_valid = 1'b0;
        a        = 4'($urandom_range(0, 15));
        b        = 4'($urandom_range(0, 15));
        mode     = 2'($urandom_range(0, 3));
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        a        = '0;
        b        = '0;
        mode     = '0;
        in_valid = 1'b0;
        #2;
        chk_out("reset_initial", 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        apply(4'd7, 4'd2, 2'b00);
        chk_out("wrap_7_2", 9, 0, 1, 1);
        apply(4'd3, 4'd4, 2'b00);
        chk_out("wrap_3_4", 7, 0, 0, 1);

        // Asynchronous reset while out_valid is high, between clock edges.
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("reset_async", 0, 0, 0, 0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_out("reset_hold1", 0, 0, 0, 0);
        idle_cycle();
        chk_out("reset_hold2", 0, 0, 0, 0);

        apply(4'd15, 4'd1, 2'b00);
        chk_out("wrap_15_1", 0, 1, 0, 1);
        apply(4'd8, 4'd8, 2'b00);
        chk_out("wrap_8_8", 0, 1, 1, 1);

        apply(4'd12, 4'd9, 2'b01);
        chk_out("usat_12_9", 15, 1, 1, 1);
        apply(4'd3, 4'd4, 2'b01);
        chk_out("usat_3_4", 7, 0, 0, 1);

        apply(4'd7, 4'd2, 2'b10);
        chk_out("ssat_7_2", 7, 0, 1, 1);
        apply(4'd8, 4'd15, 2'b10);
        chk_out("ssat_8_15", 8, 1, 1, 1);
        apply(4'd2, 4'd14, 2'b10);
        chk_out("ssat_2_m2", 0, 1, 0, 1);

        apply(4'd6, 4'd5, 2'b11);
        chk_out("mode11_6_5", 11, 0, 1, 1);
        apply(4'd12, 4'd9, 2'b11);
        chk_out("mode11_12_9", 5, 1, 1, 1);

        idle_cycle();
        chk_out("gap", 5, 1, 1, 0);

        apply(4'd1, 4'd2, 2'b00);
        chk_out("b2b_1", 3, 0, 0, 1);
        apply(4'd5, 4'd6, 2'b00);
        chk_out("b2b_2", 11, 0, 1, 1);
        apply(4'd9, 4'd9, 2'b00);
        chk_out("b2b_3", 2, 1, 1, 1);
        idle_cycle();
        chk_out("hold_1", 2, 1, 1, 0);
        idle_cycle();
        chk_out("hold_2", 2, 1, 1, 0);
        idle_cycle();
        chk_out("hold_3", 2, 1, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/simple_adder.md
Name: simple_adder

Overview:
Registered WIDTH-bit two-operand adder with status flags and selectable wrap/saturate modes, used as a small arithmetic leaf in the datapath. Operands are sampled on a valid strobe. Sum and flags are presented one clock later. Default WIDTH=4. Results 0..15 are exact in wrap mode: 7+2 gives 9, 3+4 gives 7.

Parameters:
WIDTH, 4, operand and sum width in bits (legal range ≥ 2).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
a  input  WIDTH  operand A (unsigned or two's complement, per mode)
b  input  WIDTH  operand B
in_valid  input  1  operands valid this cycle; sample when high
mode  input  2  00 wrap, 01 unsigned saturate, 10 signed saturate, 11 treated as wrap
sum  output  WIDTH  registered result
carry_out  output  1  unsigned carry out of the raw addition
overflow  output  1  two's-complement overflow of the raw addition
out_valid  output  1  high for one cycle when sum/flags are updated

Behaviour:
- Reset (rst_n low, asynchronous, any time including mid-operation): sum=0, carry_out=0, overflow=0, out_valid=0 immediately. Outputs stay 0 until the first sampled operation after rst_n rises.
- Raw addition: raw = a + b computed WIDTH+1 bits wide, zero-extended.
- carry_out = raw[WIDTH].
- overflow = (a[MSB] == b[MSB]) && (raw[MSB] != a[MSB]).
- Both flags are computed from the raw addition in every mode, independent of saturation.
- Result selection:
  - mode 00/11: sum = raw[WIDTH-1:0] (modulo 2^WIDTH).
  - mode 01: if carry_out, sum = all ones (15 for WIDTH=4); else raw[WIDTH-1:0].
  - mode 10: if overflow and a[MSB]=0, sum = max positive (0111); if overflow and a[MSB]=1, sum = min negative (1000); else raw[WIDTH-1:0].
- Latency: exactly 1 cycle. Operands and mode are sampled at the rising edge where in_valid=1. sum, carry_out and overflow update at that same edge. out_valid=1 during the following cycle.
- If in_valid=0 at an edge: sum, carry_out and overflow hold their previous values; out_valid=0.
- Back-to-back in_valid: one result per cycle, no bubbles, no backpressure.
- No combinational path from inputs to outputs.
- Changes to a, b or mode between sampling edges have no effect.

Test Plan:
- Reset: assert rst_n=0 mid-stream with out_valid=1 -> all outputs 0 immediately, without waiting for a clock edge; they stay 0 after release until the next in_valid.
- Wrap: a=7, b=2, mode=00, in_valid pulse -> next cycle sum=9, carry_out=0, overflow=1, out_valid=1. Then a=3, b=4 -> sum=7, carry_out=0, overflow=0.
- Wrap-around: a=15, b=1, mode=00 -> sum=0, carry_out=1, overflow=0. a=8, b=8 -> sum=0, carry_out=1, overflow=1.
- Unsigned saturate: a=12, b=9, mode=01 -> sum=15, carry_out=1. a=3, b=4 -> sum=7.
- Signed saturate: a=7, b=2, mode=10 -> sum=7 (0111), overflow=1. a=8, b=15, mode=10 -> sum=8 (1000), overflow=1. a=2, b=14 (−2), mode=10 -> sum=0, overflow=0.
- Hold/throughput: three back-to-back valid pairs then in_valid=0 with changing a/b -> three consecutive correct results with out_valid high, then out_valid=0 and sum held at the last result.
